// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: button filtering, frame-paced step requests issued in
// vertical blanking, score/speed tracking and the IDLE/RUN/WAIT_STEP/OVER flow.
module snake_game_ctrl #(
    parameter int FRAMES_PER_STEP_INIT = 8,
    parameter int MIN_FRAMES           = 2,
    parameter int SPEEDUP_EVERY        = 4,
    parameter int OVER_HOLD_FRAMES     = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    input  logic       step_done,
    input  logic       collision,
    input  logic       food_eaten,
    output logic       step,
    output logic       clear,
    output logic [1:0] dir,
    output logic [1:0] state,
    output logic [7:0] score,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_WAIT = 2'b10,
        ST_OVER = 2'b11
    } state_t;

    localparam logic [5:0] PERIOD_INIT = 6'(FRAMES_PER_STEP_INIT);
    localparam logic [5:0] PERIOD_MIN  = 6'(MIN_FRAMES);
    localparam logic [7:0] SPEEDUP_W   = 8'(SPEEDUP_EVERY);
    localparam logic [7:0] HOLD_MAX    = 8'(OVER_HOLD_FRAMES);

    // Button bit index equals its direction code: 0 right, 1 left, 2 up, 3 down.
    logic [3:0] btn_raw;
    logic [3:0] btn_meta_q, btn_sync_q;

    state_t     state_q, state_d;
    logic [1:0] dir_q, dir_d;
    logic [1:0] pend_q, pend_d;
    logic [7:0] score_q, score_d;
    logic [5:0] period_q, period_d;
    logic [5:0] frame_cnt_q, frame_cnt_d;
    logic [7:0] hold_q, hold_d;
    logic       launch_q, launch_d;
    logic       step_q, step_d;
    logic       clear_q, clear_d;
    logic       busy_q, busy_d;

    logic       press_valid;
    logic [1:0] press_dir;
    logic       accept_turn;
    logic       start_game;
    logic [7:0] score_inc;

    assign btn_raw = {down, up, left, right};

    always_comb begin
        press_valid = 1'b1;
        press_dir   = 2'b00;
        case (btn_sync_q)
            4'b0001: press_dir = 2'b00;
            4'b0010: press_dir = 2'b01;
            4'b0100: press_dir = 2'b10;
            4'b1000: press_dir = 2'b11;
            default: press_valid = 1'b0;
        endcase
    end

    // Reverse of a direction differs only in the low bit.
    assign accept_turn = press_valid && ((press_dir ^ 2'b01) != dir_q);
    assign score_inc   = score_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        pend_d      = pend_q;
        score_d     = score_q;
        period_d    = period_q;
        frame_cnt_d = frame_cnt_q;
        hold_d      = hold_q;
        launch_d    = 1'b0;
        clear_d     = 1'b0;
        start_game  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (press_valid) start_game = 1'b1;
            end
            ST_RUN: begin
                if (accept_turn) pend_d = press_dir;
                if (frame_start) begin
                    if (frame_cnt_q + 6'd1 == period_q) begin
                        frame_cnt_d = 6'd0;
                        dir_d       = pend_d;
                        state_d     = ST_WAIT;
                        launch_d    = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 6'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (accept_turn) pend_d = press_dir;
                if (step_done) begin
                    if (collision) begin
                        state_d = ST_OVER;
                        hold_d  = 8'd0;
                    end else begin
                        if (food_eaten && score_q != 8'hFF) begin
                            score_d = score_inc;
                            if ((score_inc % SPEEDUP_W) == 8'd0 && period_q > PERIOD_MIN)
                                period_d = period_q - 6'd1;
                        end
                        state_d = ST_RUN;
                    end
                end
            end
            ST_OVER: begin
                if (frame_start && hold_q != HOLD_MAX) hold_d = hold_q + 8'd1;
                if (hold_q == HOLD_MAX && press_valid) start_game = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_game) begin
            clear_d     = 1'b1;
            dir_d       = press_dir;
            pend_d      = press_dir;
            score_d     = 8'd0;
            period_d    = PERIOD_INIT;
            frame_cnt_d = 6'd0;
            state_d     = ST_RUN;
        end

        busy_d = (state_d == ST_WAIT);
        // Step fires the cycle after the commit edge, only if still waiting on it.
        step_d = launch_q && (state_q == ST_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q  <= 4'b0;
            btn_sync_q  <= 4'b0;
            state_q     <= ST_IDLE;
            dir_q       <= 2'b00;
            pend_q      <= 2'b00;
            score_q     <= 8'd0;
            period_q    <= PERIOD_INIT;
            frame_cnt_q <= 6'd0;
            hold_q      <= 8'd0;
            launch_q    <= 1'b0;
            step_q      <= 1'b0;
            clear_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            btn_meta_q  <= btn_raw;
            btn_sync_q  <= btn_meta_q;
            state_q     <= state_d;
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            score_q     <= score_d;
            period_q    <= period_d;
            frame_cnt_q <= frame_cnt_d;
            hold_q      <= hold_d;
            launch_q    <= launch_d;
            step_q      <= step_d;
            clear_q     <= clear_d;
            busy_q      <= busy_d;
        end
    end

    assign step  = step_q;
    assign clear = clear_q;
    assign dir   = dir_q;
    assign state = state_q;
    assign score = score_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl: start flow, turning, speed-up, game over,
// asynchronous reset and score saturation, each as its own scenario task.
module tb_snake_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
    logic       step_done = 1'b0, collision = 1'b0, food_eaten = 1'b0;
    logic       step, clear, busy;
    logic [1:0] dir, state;
    logic [7:0] score;

    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_period = 8;
    int exp_score = 0;

    snake_game_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .left(left), .right(right), .up(up), .down(down),
        .step_done(step_done), .collision(collision), .food_eaten(food_eaten),
        .step(step), .clear(clear), .dir(dir), .state(state),
        .score(score), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [3:0] m);
        {down, up, left, right} = m;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic flush_btn();
        set_btn(4'b0000);
        repeat (3) tick();
    endtask

    // Runs n frames, then services the step with the given flags; reports timing.
    task automatic do_step(input int n, input bit food, input bit coll,
                           output bit early_ok, output bit wait_ok, output bit step_ok);
        for (int i = 0; i < n - 1; i++) begin
            frame();
            tick();
        end
        early_ok = (state == 2'b01) && !busy && !step;
        frame();
        wait_ok = (state == 2'b10) && busy && !step;
        tick();
        step_ok = step && !clear;
        tick();
        step_ok = step_ok && !step;
        step_done = 1'b1; food_eaten = food; collision = coll;
        tick();
        step_done = 1'b0; food_eaten = 1'b0; collision = 1'b0;
    endtask

    task automatic model_food();
        if (exp_score < 255) begin
            exp_score++;
            if (exp_score % 4 == 0 && exp_period > 2) exp_period--;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        total_cnt++; if (state !== 2'b00) $display("FAIL reset_state got=%0d want=0", state); else pass_cnt++;
        total_cnt++; if (dir !== 2'b00) $display("FAIL reset_dir got=%0d want=0", dir); else pass_cnt++;
        total_cnt++; if (score !== 8'd0) $display("FAIL reset_score got=%0d want=0", score); else pass_cnt++;
        total_cnt++; if ({step, clear, busy} !== 3'b000) $display("FAIL reset_pulses got=%b want=000", {step, clear, busy}); else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_start();
        bit e, w, s;
        set_btn(4'b0100);
        repeat (2) tick();
        total_cnt++; if (clear !== 1'b0) $display("FAIL start_sync_latency clear=%b want=0", clear); else pass_cnt++;
        tick();
        total_cnt++; if (clear !== 1'b1) $display("FAIL start_clear got=%b want=1", clear); else pass_cnt++;
        total_cnt++; if (state !== 2'b01 || dir !== 2'b10) $display("FAIL start_state_dir got=%0d/%0d want=1/2", state, dir); else pass_cnt++;
        set_btn(4'b0000);
        tick();
        total_cnt++; if (clear !== 1'b0) $display("FAIL start_clear_once got=%b want=0", clear); else pass_cnt++;
        repeat (2) tick();
        exp_period = 8; exp_score = 0;
        do_step(8, 1'b0, 1'b0, e, w, s);
        total_cnt++; if ({e, w, s} !== 3'b111) $display("FAIL first_step_timing got=%b want=111", {e, w, s}); else pass_cnt++;
        total_cnt++; if (state !== 2'b01 || busy !== 1'b0) $display("FAIL step_done_to_run got=%0d/%b want=1/0", state, busy); else pass_cnt++;
    endtask

    task automatic test_direction();
        bit e, w, s;
        set_btn(4'b0001); repeat (3) tick(); flush_btn();
        do_step(exp_period, 1'b0, 1'b0, e, w, s);
        total_cnt++; if (dir !== 2'b00) $display("FAIL turn_right got=%0d want=0", dir); else pass_cnt++;
        set_btn(4'b0010); repeat (3) tick(); flush_btn();
        do_step(exp_period, 1'b0, 1'b0, e, w, s);
        total_cnt++; if (dir !== 2'b00) $display("FAIL reverse_dropped got=%0d want=0", dir); else pass_cnt++;
        set_btn(4'b0100); repeat (3) tick(); flush_btn();
        total_cnt++; if (dir !== 2'b00) $display("FAIL dir_before_commit got=%0d want=0", dir); else pass_cnt++;
        do_step(exp_period, 1'b0, 1'b0, e, w, s);
        total_cnt++; if (dir !== 2'b10) $display("FAIL turn_up got=%0d want=2", dir); else pass_cnt++;
    endtask

    task automatic test_speedup();
        bit e, w, s;
        for (int k = 1; k <= 32; k++) begin
            do_step(exp_period, 1'b1, 1'b0, e, w, s);
            total_cnt++; if ({e, w, s} !== 3'b111) $display("FAIL speed_timing k=%0d period=%0d got=%b want=111", k, exp_period, {e, w, s}); else pass_cnt++;
            model_food();
            if (k % 4 == 0) begin
                total_cnt++; if (score !== 8'(exp_score)) $display("FAIL speed_score k=%0d got=%0d want=%0d", k, score, exp_score); else pass_cnt++;
            end
        end
    endtask

    task automatic test_game_over();
        bit e, w, s;
        do_step(exp_period, 1'b1, 1'b1, e, w, s);
        total_cnt++; if (state !== 2'b11 || busy !== 1'b0) $display("FAIL over_state got=%0d/%b want=3/0", state, busy); else pass_cnt++;
        total_cnt++; if (score !== 8'(exp_score)) $display("FAIL over_score_kept got=%0d want=%0d", score, exp_score); else pass_cnt++;
        repeat (10) begin frame(); tick(); end
        set_btn(4'b0100); repeat (3) tick();
        total_cnt++; if (clear !== 1'b0 || state !== 2'b11) $display("FAIL over_early_press clear=%b state=%0d want=0/3", clear, state); else pass_cnt++;
        flush_btn();
        repeat (109) begin frame(); tick(); end
        set_btn(4'b0001); repeat (3) tick();
        total_cnt++; if (clear !== 1'b0 || state !== 2'b11) $display("FAIL over_press_at_119 clear=%b state=%0d want=0/3", clear, state); else pass_cnt++;
        flush_btn();
        frame(); tick();
        set_btn(4'b0001); repeat (3) tick();
        total_cnt++; if (clear !== 1'b1 || state !== 2'b01) $display("FAIL over_restart clear=%b state=%0d want=1/1", clear, state); else pass_cnt++;
        total_cnt++; if (score !== 8'd0 || dir !== 2'b00) $display("FAIL over_restart_score_dir got=%0d/%0d want=0/0", score, dir); else pass_cnt++;
        set_btn(4'b0000); tick();
        total_cnt++; if (clear !== 1'b0) $display("FAIL over_clear_once got=%b want=0", clear); else pass_cnt++;
        repeat (2) tick();
        exp_period = 8; exp_score = 0;
    endtask

    task automatic test_async_reset();
        bit e, w, s;
        do_step(exp_period, 1'b1, 1'b0, e, w, s);
        model_food();
        total_cnt++; if (score !== 8'd1) $display("FAIL pre_reset_score got=%0d want=1", score); else pass_cnt++;
        for (int i = 0; i < exp_period - 1; i++) begin frame(); tick(); end
        frame();
        total_cnt++; if (state !== 2'b10) $display("FAIL pre_reset_wait got=%0d want=2", state); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (state !== 2'b00 || {step, busy} !== 2'b00) $display("FAIL async_reset_state got=%0d/%b want=0/00", state, {step, busy}); else pass_cnt++;
        total_cnt++; if (score !== 8'd0 || dir !== 2'b00) $display("FAIL async_reset_score_dir got=%0d/%0d want=0/0", score, dir); else pass_cnt++;
        tick();
        total_cnt++; if (step !== 1'b0) $display("FAIL async_reset_no_step got=%b want=0", step); else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_saturate();
        bit e, w, s;
        int bad;
        set_btn(4'b1000); repeat (3) tick();
        total_cnt++; if (clear !== 1'b1 || dir !== 2'b11 || state !== 2'b01) $display("FAIL sat_start got=%b/%0d/%0d want=1/3/1", clear, dir, state); else pass_cnt++;
        flush_btn();
        exp_period = 8; exp_score = 0; bad = 0;
        for (int k = 0; k < 255; k++) begin
            do_step(exp_period, 1'b1, 1'b0, e, w, s);
            if ({e, w, s} !== 3'b111) bad++;
            model_food();
        end
        total_cnt++; if (bad != 0) $display("FAIL sat_step_timing bad_steps=%0d want=0", bad); else pass_cnt++;
        total_cnt++; if (score !== 8'd255) $display("FAIL sat_reach got=%0d want=255", score); else pass_cnt++;
        do_step(exp_period, 1'b1, 1'b0, e, w, s);
        total_cnt++; if (score !== 8'd255) $display("FAIL sat_no_wrap got=%0d want=255", score); else pass_cnt++;
        step_done = 1'b1; food_eaten = 1'b1; collision = 1'b1; tick();
        step_done = 1'b0; food_eaten = 1'b0; collision = 1'b0; tick();
        total_cnt++; if (state !== 2'b01 || score !== 8'd255) $display("FAIL ignored_step_done got=%0d/%0d want=1/255", state, score); else pass_cnt++;
        set_btn(4'b0011); repeat (3) tick(); flush_btn();
        total_cnt++; if (state !== 2'b01) $display("FAIL two_button_state got=%0d want=1", state); else pass_cnt++;
        do_step(exp_period, 1'b0, 1'b0, e, w, s);
        total_cnt++; if (dir !== 2'b11) $display("FAIL two_button_dir got=%0d want=3", dir); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_start();
        test_direction();
        test_speedup();
        test_game_over();
        test_async_reset();
        test_saturate();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
